sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/npu_sram_pkg.sv | 7 +
 rtl/sram_port_arbiter_rr_pick.sv | 19 +
 rtl/sram_port_arbiter.sv | 89 ++++++++
 tb/tb_sram_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_sram_pkg.sv
// npu_sram_pkg: shared SRAM port widths and arbiter state encoding
package npu_sram_pkg;
  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_BE_W = 2;
  typedef enum logic {IDLE, OWNED} arb_state_t;
endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// rr_pick: one-hot round-robin pick of the first requester at or after ptr
module rr_pick #(
  parameter int N = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);
  logic [PW-1:0] idx;
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) pick = N'(1) << idx;
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one SRAM port with locked bursts
module sram_port_arbiter
  import npu_sram_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int MAX_BURST = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             lock,
  input  logic [NUM_REQ-1:0]             we,
  input  logic [NUM_REQ*SRAM_ADDR_W-1:0] addr,
  input  logic [NUM_REQ*SRAM_BE_W-1:0]   be,
  input  logic [NUM_REQ*SRAM_DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [SRAM_DATA_W-1:0]         rdata,
  output logic [SRAM_ADDR_W-1:0]         sram_address,
  output logic [SRAM_BE_W-1:0]           sram_byteenable,
  output logic                           sram_chipselect,
  output logic                           sram_write,
  output logic [SRAM_DATA_W-1:0]         sram_writedata,
  input  logic [SRAM_DATA_W-1:0]         sram_readdata
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  arb_state_t state;
  logic [PW-1:0] ptr, owner, gi, rv_lane;
  logic [BW-1:0] burst;
  logic rv_flag, g_lock;
  logic [NUM_REQ-1:0] pick;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
    return (i == PW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (.req(req), .ptr(ptr), .pick(pick));
  assign gnt = !reset_n ? '0 :
               (state == OWNED) ? ({NUM_REQ{req[owner]}} & (NUM_REQ'(1) << owner)) : pick;
  always_comb begin
    gi = '0;
    g_lock = 1'b0;
    sram_write = 1'b0;
    sram_address = '0;
    sram_byteenable = '0;
    sram_writedata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        gi = PW'(i);
        g_lock = lock[i];
        sram_write = we[i];
        sram_address = addr[i*SRAM_ADDR_W +: SRAM_ADDR_W];
        sram_byteenable = be[i*SRAM_BE_W +: SRAM_BE_W];
        sram_writedata = wdata[i*SRAM_DATA_W +: SRAM_DATA_W];
      end
  end
  assign sram_chipselect = |gnt;
  assign rvalid = {NUM_REQ{rv_flag}} & (NUM_REQ'(1) << rv_lane);
  assign rdata = sram_readdata;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      burst <= '0;
      rv_flag <= 1'b0;
      rv_lane <= '0;
    end else begin
      rv_flag <= sram_chipselect & ~sram_write;
      rv_lane <= gi;
      if (sram_chipselect) begin
        if (state == IDLE) begin
          if (g_lock && MAX_BURST > 1) begin
            state <= OWNED;
            owner <= gi;
            burst <= BW'(1);
          end else begin
            ptr <= nxt(gi);
          end
        end else if (!g_lock || burst == BW'(MAX_BURST - 1)) begin
          state <= IDLE;
          burst <= '0;
          ptr <= nxt(owner);
        end else begin
          burst <= burst + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: table, directed and random checks against a transaction-level model
module tb_sram_port_arbiter;
  localparam int N = 3;
  localparam int MB = 8;
  typedef struct {
    logic [N-1:0] req, lock, we, eg, erv;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req, lock, we, gnt, rvalid;
  logic [N*12-1:0] addr;
  logic [N*2-1:0] be;
  logic [N*16-1:0] wdata;
  logic [15:0] rdata, sram_writedata, sram_readdata;
  logic [11:0] sram_address;
  logic [1:0] sram_byteenable;
  logic sram_chipselect, sram_write;
  int n_pass = 0, n_tot = 0;
  bit m_owned, m_rk;
  int m_owner, m_ptr, m_cnt, m_rv;
  logic [15:0] m_rd;
  logic [15:0] shadow [4096];
  bit known [4096];
  logic [N-1:0] e_gnt = '0, s_gnt, s_rv;
  logic [15:0] s_rdata;
  logic s_wr;
  logic [15:0] mem [4096];
  logic [11:0] rd_addr = '0;
  vec_t tbl [9];
  always #5 clk = ~clk;
  sram_port_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .we(we), .addr(addr),
    .be(be), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable),
    .sram_chipselect(sram_chipselect), .sram_write(sram_write),
    .sram_writedata(sram_writedata), .sram_readdata(sram_readdata)
  );
  always @(posedge clk)
    if (sram_chipselect) begin
      if (sram_write)
        mem[sram_address] <= {sram_byteenable[1] ? sram_writedata[15:8] : mem[sram_address][15:8],
                              sram_byteenable[0] ? sram_writedata[7:0] : mem[sram_address][7:0]};
      else
        rd_addr <= sram_address;
    end
  assign sram_readdata = mem[rd_addr];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic model_reset();
    m_owned = 0;
    m_owner = 0;
    m_ptr = 0;
    m_cnt = 0;
    m_rv = -1;
  endtask
  task automatic set_lane(input int i, input bit r, input bit l, input bit w,
                          input logic [11:0] a, input logic [1:0] b, input logic [15:0] d);
    req[i] = r;
    lock[i] = l;
    we[i] = w;
    addr[i*12 +: 12] = a;
    be[i*2 +: 2] = b;
    wdata[i*16 +: 16] = d;
  endtask
  task automatic clear();
    req = '0;
    lock = '0;
    we = '0;
  endtask
  task automatic step();
    int g, a;
    logic [N-1:0] erv;
    logic [31:0] es;
    logic [1:0] b;
    logic [15:0] d;
    #1;
    g = -1;
    if (m_owned) begin
      if (req[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < N && g < 0; k++)
        if (req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    e_gnt = '0;
    if (g >= 0) e_gnt[g] = 1'b1;
    erv = '0;
    if (m_rv >= 0) erv[m_rv] = 1'b1;
    es = (g < 0) ? 32'h0 : {1'b1, we[g], addr[g*12 +: 12], be[g*2 +: 2], wdata[g*16 +: 16]};
    chk("gnt", gnt, e_gnt);
    chk("rvalid", rvalid, erv);
    chk("sram_port", {sram_chipselect, sram_write, sram_address, sram_byteenable, sram_writedata}, es);
    if (m_rv >= 0 && m_rk) chk("rdata", rdata, m_rd);
    s_gnt = gnt;
    s_rv = rvalid;
    s_rdata = rdata;
    s_wr = sram_write;
    m_rv = -1;
    if (g >= 0) begin
      a = int'(addr[g*12 +: 12]);
      b = be[g*2 +: 2];
      d = wdata[g*16 +: 16];
      if (we[g]) begin
        if (b[0]) shadow[a][7:0] = d[7:0];
        if (b[1]) shadow[a][15:8] = d[15:8];
        if (b == 2'b11) known[a] = 1;
      end else begin
        m_rv = g;
        m_rd = shadow[a];
        m_rk = known[a];
      end
      if (!m_owned) begin
        if (lock[g] && MB > 1) begin
          m_owned = 1;
          m_owner = g;
          m_cnt = 1;
        end else m_ptr = (g + 1) % N;
      end else begin
        m_cnt++;
        if (!lock[g] || m_cnt == MB) begin
          m_owned = 0;
          m_cnt = 0;
          m_ptr = (m_owner + 1) % N;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    clear();
    addr = '0;
    be = '0;
    wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    req = '1;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_sram", {sram_chipselect, sram_write, sram_address, sram_byteenable, sram_writedata}, 0);
    chk("rst_rdata", rdata, sram_readdata);
    req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tbl[0] = '{3'b111, 3'b000, 3'b000, 3'b001, 3'b000};
    tbl[1] = '{3'b111, 3'b000, 3'b000, 3'b010, 3'b001};
    tbl[2] = '{3'b111, 3'b000, 3'b000, 3'b100, 3'b010};
    tbl[3] = '{3'b111, 3'b000, 3'b000, 3'b001, 3'b100};
    tbl[4] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
    tbl[5] = '{3'b101, 3'b000, 3'b101, 3'b100, 3'b000};
    tbl[6] = '{3'b101, 3'b000, 3'b101, 3'b001, 3'b000};
    tbl[7] = '{3'b110, 3'b000, 3'b000, 3'b010, 3'b000};
    tbl[8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010};
    for (int i = 0; i < N; i++) set_lane(i, 0, 0, 0, 12'h010 + 12'(i), 2'b11, 16'hA000 + 16'(i));
    foreach (tbl[v]) begin
      req = tbl[v].req;
      lock = tbl[v].lock;
      we = tbl[v].we;
      step();
      chk("tbl_gnt", s_gnt, tbl[v].eg);
      chk("tbl_rvalid", s_rv, tbl[v].erv);
    end
    clear();
    set_lane(1, 1, 0, 1, 12'hFFF, 2'b11, 16'hBEEF);
    step();
    chk("wr_gnt", s_gnt, 3'b010);
    chk("wr_strobe", s_wr, 1);
    set_lane(1, 1, 0, 0, 12'hFFF, 2'b11, 16'h0000);
    step();
    chk("rd_gnt", s_gnt, 3'b010);
    chk("rd_strobe", s_wr, 0);
    clear();
    step();
    chk("rd_rvalid", s_rv, 3'b010);
    chk("rd_data", s_rdata, 16'hBEEF);
    set_lane(2, 1, 0, 0, 12'h001, 2'b11, 16'h0);
    step();
    chk("pre_burst_gnt", s_gnt, 3'b100);
    set_lane(0, 1, 1, 0, 12'h002, 2'b11, 16'h0);
    for (int k = 0; k < MB; k++) begin
      step();
      chk("burst_gnt", s_gnt, 3'b001);
    end
    step();
    chk("burst_release", s_gnt, 3'b100);
    clear();
    step();
    set_lane(0, 1, 1, 0, 12'h003, 2'b11, 16'h0);
    step();
    chk("lock_gnt", s_gnt, 3'b001);
    req[0] = 1'b0;
    set_lane(1, 1, 0, 0, 12'h004, 2'b11, 16'h0);
    repeat (2) begin
      step();
      chk("reserved_slot", s_gnt, 3'b000);
    end
    set_lane(0, 1, 0, 0, 12'h003, 2'b11, 16'h0);
    step();
    chk("owner_regrant", s_gnt, 3'b001);
    req[0] = 1'b0;
    step();
    chk("after_release", s_gnt, 3'b010);
    clear();
    set_lane(0, 1, 0, 1, 12'h000, 2'b11, 16'hFFFF);
    step();
    set_lane(0, 1, 0, 1, 12'h000, 2'b01, 16'h1234);
    step();
    set_lane(0, 1, 0, 0, 12'h000, 2'b11, 16'h0000);
    step();
    clear();
    step();
    chk("be_rvalid", s_rv, 3'b001);
    chk("be_data", s_rdata, 16'hFF34);
    set_lane(1, 1, 0, 0, 12'h005, 2'b11, 16'h0);
    step();
    chk("ptr_move_gnt", s_gnt, 3'b010);
    clear();
    set_lane(2, 1, 0, 0, 12'h006, 2'b11, 16'h0);
    #1;
    chk("pre_rst_gnt", gnt, 3'b100);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("in_rst_gnt", gnt, 0);
    @(posedge clk);
    @(negedge clk);
    chk("in_rst_rvalid", rvalid, 0);
    req = '1;
    reset_n = 1'b1;
    step();
    chk("post_rst_gnt", s_gnt, 3'b001);
    chk("post_rst_rvalid", s_rv, 3'b000);
    step();
    chk("post_rst_gnt2", s_gnt, 3'b010);
    chk("post_rst_rvalid2", s_rv, 3'b001);
    clear();
    step();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] || e_gnt[i]) begin
          if ($urandom_range(9) < 7)
            set_lane(i, 1, $urandom_range(9) < 3, 1'($urandom_range(1)),
                     12'h200 + 12'($urandom_range(7)), 2'($urandom_range(3)), 16'($urandom));
          else
            set_lane(i, 0, 0, 0, 12'h000, 2'b00, 16'h0);
        end
      step();
    end
    clear();
    step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
